rgmii_tx_rate_ctrl: RTL
=======================

// Module: rgmii_tx_rate_ctrl
// PURPOSE
//  Multi-channel RGMII transmit rate controller: for CHANNELS independent GMII MAC
//  ports sharing one 125 MHz clock, generates per-channel DDR register inputs for TXC/TD/TX_CTL
//  (fed to external oddr instances) and the MAC byte-strobe clk_en for 10/100/1000M.
//  Adds per-channel speed, frame-safe speed switching, divisor parameters, registered outputs.
// PARAMETERS
//  CHANNELS   1   number of independent RGMII TX channels (1..16)
//  DIV_10M    50  clk cycles per 10M TXC period (>=4)
//  DIV_100M   5   clk cycles per 100M TXC period (>=4)
//  LPI_STOP   16  cycles of LPI at 1000M before TXC is stopped (RGMII_TX_LPI_EN only)
// PORTS
//  clk               in   1            125 MHz TX clock; everything synchronous to it
//  rst               in   1            synchronous reset, active-high
//  speed             in   2*CHANNELS   requested speed per channel: 00=10M 01=100M 1x=1000M
//  gmii_txd          in   8*CHANNELS   MAC transmit byte per channel
//  gmii_tx_en        in   CHANNELS     MAC transmit enable
//  gmii_tx_er        in   CHANNELS     MAC transmit error
//  gmii_clk_en       out  CHANNELS     MAC byte strobe; MAC advances a byte when high
//  speed_act         out  2*CHANNELS   speed currently in effect per channel
//  txc_d1/txc_d2     out  CHANNELS     TXC rising/falling-edge value (to clk90 oddr)
//  td_d1/td_d2       out  4*CHANNELS   TD rising/falling-edge nibble
//  tx_ctl_d1/_d2     out  CHANNELS     TX_CTL rising/falling-edge value
//  tx_lpi            in   CHANNELS     request LPI (RGMII_TX_LPI_EN only)
//  lpi_active        out  CHANNELS     LPI being signalled (RGMII_TX_LPI_EN only)
// BEHAVIOUR
//  - Channels fully independent; all outputs registered, 1 clk latency from inputs.
//  - Reset: cnt=0, speed_act=10 (1000M), txc_d1=1 txc_d2=0, td=0, tx_ctl=0, gmii_clk_en=1,
//    lpi_active=0. Reset mid-frame aborts immediately; no partial nibble emitted after rst.
//  - 1000M: gmii_clk_en=1 every cycle; txc 1/0; td_d1=txd[3:0], td_d2=txd[7:4];
//    tx_ctl_d1=tx_en, tx_ctl_d2=tx_en^tx_er.
//  - 10/100M, DIV=DIV_10M/DIV_100M, H=DIV/2 (floor): cnt 0..DIV-1 wraps to 0.
//    txc_d1=txc_d2=1 for cnt<H; cnt==H with DIV odd: d1=1,d2=0; else 0/0.
//    gmii_clk_en=1 only in cycle cnt==DIV-1 (one strobe per period); byte captured in that
//    cycle into hold reg; td_d1=td_d2=hold[3:0] for the following period;
//    tx_ctl = tx_en while txc high, tx_en^tx_er while txc low (both edges equal).
//    Upper nibble unused at 10/100 (MAC repeats nibble per byte).
//  - Speed switch: speed_act updates from speed only when channel idle (tx_en=0 at capture)
//    and at a period boundary (1000M: any cycle; 10/100: cnt==DIV-1). Change during a frame
//    deferred until frame end; cnt reset to 0 on switch. speed=11 treated as 1000M.
//  - Simultaneous speed change and tx_en rise on boundary: tx_en wins, switch deferred.
// CONFIGURATION
//  RGMII_TX_LPI_EN defined: tx_lpi/lpi_active ports present. tx_lpi=1 with tx_en=0 at
//    capture -> emit tx_en=0,tx_er=1,txd=8'h01 encoding (ctl 0/1, td 1/0 at 1000M);
//    lpi_active=1. At 1000M after LPI_STOP consecutive LPI cycles txc_d1=txc_d2=0 until
//    tx_lpi drops; TXC restarts first cycle, LPI encoding kept one more period, then idle.
//    tx_en=1 overrides tx_lpi. Speed switch allowed during LPI.
//  Undefined: ports absent; LPI encoding never generated; txc never stopped.
// STRUCTURE
//  - rgmii_pkg: SPEED_10M/100M/1000M codes, LPI_TXD constant, cnt width function.
//  - Sub-module rgmii_tx_rate_ch (one channel: counter, speed latch, hold reg, output regs),
//    instantiated CHANNELS times in a generate loop; top only slices buses.
// TESTING
//  - rst, speed=10, tx_en=1 txd=8'hA5 -> next clk td_d1=5 td_d2=A, ctl 1/1, clk_en always 1.
//  - speed=01, DIV=5: txc pattern 11,11,10,00,00 repeating; clk_en high 1 of 5; txd=8'h3C
//    captured -> td 4'hC both edges for 5 cycles; tx_er=1 -> ctl 1 high-phase, 0 low-phase.
//  - speed=00: clk_en period 50, txc high 25 cycles; td holds across period.
//  - speed 10->01 while tx_en=1: speed_act stays 10 until tx_en=0, then 01, cnt from 0.
//  - CHANNELS=4 mixed speeds (10,01,00,10): each channel's clk_en/txc independent, no crosstalk.
//  - RGMII_TX_LPI_EN, 1000M, tx_lpi=1: ctl 0/1 td 1/0, lpi_active=1; after 16 cycles txc 0/0;
//    drop tx_lpi -> txc 1/0 next cycle, idle encoding after one period.

Source files
------------

// File: rtl/rgmii_tx_rate_ctrl_pkg.sv
// Shared constants and types for the multi-channel RGMII transmit rate controller.
// Consumed by the per-channel engine; LPI encoding constants apply when RGMII_TX_LPI_EN is defined.
package rgmii_tx_rate_ctrl_pkg;

    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;

    localparam logic [7:0] LPI_TXD = 8'h01;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] d;
    } gmii_byte_t;

    localparam gmii_byte_t LPI_BYTE = '{en: 1'b0, er: 1'b1, d: LPI_TXD};

    // Counter width able to hold 0..max(div_a, div_b)-1.
    function automatic int cnt_width(input int div_a, input int div_b);
        int m;
        m = (div_a > div_b) ? div_a : div_b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rgmii_tx_rate_ctrl_if.sv
// GMII-side and RGMII-DDR-side bundle for rgmii_tx_rate_ctrl, one slice per channel.
// tx_lpi / lpi_active exist only when RGMII_TX_LPI_EN is defined.
interface rgmii_tx_rate_ctrl_if #(
    parameter int CHANNELS = 1
);
    logic [2*CHANNELS-1:0] speed;
    logic [8*CHANNELS-1:0] gmii_txd;
    logic [CHANNELS-1:0]   gmii_tx_en;
    logic [CHANNELS-1:0]   gmii_tx_er;
    logic [CHANNELS-1:0]   gmii_clk_en;
    logic [2*CHANNELS-1:0] speed_act;
    logic [CHANNELS-1:0]   txc_d1;
    logic [CHANNELS-1:0]   txc_d2;
    logic [4*CHANNELS-1:0] td_d1;
    logic [4*CHANNELS-1:0] td_d2;
    logic [CHANNELS-1:0]   tx_ctl_d1;
    logic [CHANNELS-1:0]   tx_ctl_d2;
`ifdef RGMII_TX_LPI_EN
    logic [CHANNELS-1:0]   tx_lpi;
    logic [CHANNELS-1:0]   lpi_active;
`endif

    modport master (
`ifdef RGMII_TX_LPI_EN
        output tx_lpi,
        input  lpi_active,
`endif
        output speed, gmii_txd, gmii_tx_en, gmii_tx_er,
        input  gmii_clk_en, speed_act, txc_d1, txc_d2, td_d1, td_d2, tx_ctl_d1, tx_ctl_d2
    );

    modport slave (
`ifdef RGMII_TX_LPI_EN
        input  tx_lpi,
        output lpi_active,
`endif
        input  speed, gmii_txd, gmii_tx_en, gmii_tx_er,
        output gmii_clk_en, speed_act, txc_d1, txc_d2, td_d1, td_d2, tx_ctl_d1, tx_ctl_d2
    );

endinterface

// File: rtl/rgmii_tx_rate_ctrl_ch.sv
// One RGMII TX channel: period counter, frame-safe speed latch, byte hold and DDR output regs.
// RGMII_TX_LPI_EN adds LPI encoding and TXC stop at 1000M.
module rgmii_tx_rate_ch
    import rgmii_tx_rate_ctrl_pkg::*;
#(
    parameter int DIV_10M  = 50,
    parameter int DIV_100M = 5,
    parameter int LPI_STOP = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] txd,
    input  logic       tx_en,
    input  logic       tx_er,
`ifdef RGMII_TX_LPI_EN
    input  logic       tx_lpi,
    output logic       lpi_active,
`endif
    output logic       clk_en,
    output logic [1:0] speed_act,
    output logic       txc_d1,
    output logic       txc_d2,
    output logic [3:0] td_d1,
    output logic [3:0] td_d2,
    output logic       tx_ctl_d1,
    output logic       tx_ctl_d2
);

    localparam int CW = cnt_width(DIV_10M, DIV_100M);
    localparam int LW = $clog2(LPI_STOP + 2);

    localparam logic [CW-1:0] LAST_10  = CW'(DIV_10M - 1);
    localparam logic [CW-1:0] LAST_100 = CW'(DIV_100M - 1);
    localparam logic [CW-1:0] HALF_10  = CW'(DIV_10M / 2);
    localparam logic [CW-1:0] HALF_100 = CW'(DIV_100M / 2);
    localparam logic          ODD_10   = 1'(DIV_10M % 2);
    localparam logic          ODD_100  = 1'(DIV_100M % 2);
    localparam logic [LW-1:0] LPI_SAT  = LW'(LPI_STOP + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    speed_act_q, speed_act_d;
    gmii_byte_t    hold_q, hold_d;
    logic          lpi_prev_q, lpi_prev_d;
    logic [LW-1:0] lpi_cnt_q, lpi_cnt_d;
    logic          clk_en_q, clk_en_d;
    logic          txc_d1_q, txc_d1_d, txc_d2_q, txc_d2_d;
    logic [3:0]    td_d1_q, td_d1_d, td_d2_q, td_d2_d;
    logic          tx_ctl_d1_q, tx_ctl_d1_d, tx_ctl_d2_q, tx_ctl_d2_d;

    logic [1:0]    speed_req;
    logic          lpi_req, lpi_enc, is_gig, txc_stop, ctl_val;
    logic [CW-1:0] last_d, half_d;
    logic          odd_d;

`ifdef RGMII_TX_LPI_EN
    logic lpi_active_q, lpi_active_d;

    assign lpi_req = tx_lpi & ~tx_en;

    always_comb begin
        lpi_active_d = lpi_active_q;
        if (clk_en_q) lpi_active_d = lpi_enc;
    end

    always_ff @(posedge clk) begin
        if (rst) lpi_active_q <= 1'b0;
        else     lpi_active_q <= lpi_active_d;
    end

    assign lpi_active = lpi_active_q;
`else
    assign lpi_req = 1'b0;
`endif

    always_comb begin
        speed_req   = speed[1] ? SPEED_1000M : speed;
        // LPI encoding lingers for one extra period after the request drops.
        lpi_enc     = ~tx_en & (lpi_req | lpi_prev_q);
        speed_act_d = speed_act_q;
        hold_d      = hold_q;
        lpi_prev_d  = lpi_prev_q;

        // clk_en_q marks the capture cycle, which is also the period boundary.
        if (clk_en_q) begin
            hold_d     = lpi_enc ? LPI_BYTE : '{en: tx_en, er: tx_er, d: txd};
            lpi_prev_d = lpi_req;
            if (!tx_en && (speed_req != speed_act_q)) speed_act_d = speed_req;
        end

        is_gig = speed_act_d[1];
        if (is_gig || (speed_act_d != speed_act_q) || clk_en_q) cnt_d = '0;
        else                                                     cnt_d = cnt_q + 1'b1;

        if (lpi_req && is_gig) lpi_cnt_d = (lpi_cnt_q == LPI_SAT) ? LPI_SAT : lpi_cnt_q + 1'b1;
        else                   lpi_cnt_d = '0;
        txc_stop = (lpi_cnt_d == LPI_SAT);

        last_d = speed_act_d[0] ? LAST_100 : LAST_10;
        half_d = speed_act_d[0] ? HALF_100 : HALF_10;
        odd_d  = speed_act_d[0] ? ODD_100  : ODD_10;

        // Outputs follow the next-state counter so TXC phase and strobe line up with the state.
        if (is_gig) begin
            clk_en_d    = 1'b1;
            txc_d1_d    = ~txc_stop;
            txc_d2_d    = 1'b0;
            td_d1_d     = hold_d.d[3:0];
            td_d2_d     = hold_d.d[7:4];
            tx_ctl_d1_d = hold_d.en;
            tx_ctl_d2_d = hold_d.en ^ hold_d.er;
            ctl_val     = 1'b0;
        end else begin
            clk_en_d    = (cnt_d == last_d);
            txc_d2_d    = (cnt_d < half_d);
            txc_d1_d    = txc_d2_d | (odd_d & (cnt_d == half_d));
            td_d1_d     = hold_d.d[3:0];
            td_d2_d     = hold_d.d[3:0];
            ctl_val     = txc_d1_d ? hold_d.en : (hold_d.en ^ hold_d.er);
            tx_ctl_d1_d = ctl_val;
            tx_ctl_d2_d = ctl_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            speed_act_q <= SPEED_1000M;
            hold_q      <= '0;
            lpi_prev_q  <= 1'b0;
            lpi_cnt_q   <= '0;
            clk_en_q    <= 1'b1;
            txc_d1_q    <= 1'b1;
            txc_d2_q    <= 1'b0;
            td_d1_q     <= '0;
            td_d2_q     <= '0;
            tx_ctl_d1_q <= 1'b0;
            tx_ctl_d2_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            speed_act_q <= speed_act_d;
            hold_q      <= hold_d;
            lpi_prev_q  <= lpi_prev_d;
            lpi_cnt_q   <= lpi_cnt_d;
            clk_en_q    <= clk_en_d;
            txc_d1_q    <= txc_d1_d;
            txc_d2_q    <= txc_d2_d;
            td_d1_q     <= td_d1_d;
            td_d2_q     <= td_d2_d;
            tx_ctl_d1_q <= tx_ctl_d1_d;
            tx_ctl_d2_q <= tx_ctl_d2_d;
        end
    end

    assign clk_en    = clk_en_q;
    assign speed_act = speed_act_q;
    assign txc_d1    = txc_d1_q;
    assign txc_d2    = txc_d2_q;
    assign td_d1     = td_d1_q;
    assign td_d2     = td_d2_q;
    assign tx_ctl_d1 = tx_ctl_d1_q;
    assign tx_ctl_d2 = tx_ctl_d2_q;

endmodule

// File: rtl/rgmii_tx_rate_ctrl.sv
// Multi-channel RGMII TX rate controller top: one rgmii_tx_rate_ch per channel, buses sliced here.
// Define RGMII_TX_LPI_EN to enable the LPI request/indication path.
module rgmii_tx_rate_ctrl #(
    parameter int CHANNELS = 1,
    parameter int DIV_10M  = 50,
    parameter int DIV_100M = 5,
    parameter int LPI_STOP = 16
) (
    input logic                 clk,
    input logic                 rst,
    rgmii_tx_rate_ctrl_if.slave bus
);

    logic [CHANNELS-1:0]   clk_en_w;
    logic [2*CHANNELS-1:0] speed_act_w;
    logic [CHANNELS-1:0]   txc_d1_w, txc_d2_w, tx_ctl_d1_w, tx_ctl_d2_w;
    logic [4*CHANNELS-1:0] td_d1_w, td_d2_w;
`ifdef RGMII_TX_LPI_EN
    logic [CHANNELS-1:0]   lpi_active_w;
    assign bus.lpi_active = lpi_active_w;
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        rgmii_tx_rate_ch #(
            .DIV_10M (DIV_10M),
            .DIV_100M(DIV_100M),
            .LPI_STOP(LPI_STOP)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .speed     (bus.speed[2*gi +: 2]),
            .txd       (bus.gmii_txd[8*gi +: 8]),
            .tx_en     (bus.gmii_tx_en[gi]),
            .tx_er     (bus.gmii_tx_er[gi]),
`ifdef RGMII_TX_LPI_EN
            .tx_lpi    (bus.tx_lpi[gi]),
            .lpi_active(lpi_active_w[gi]),
`endif
            .clk_en    (clk_en_w[gi]),
            .speed_act (speed_act_w[2*gi +: 2]),
            .txc_d1    (txc_d1_w[gi]),
            .txc_d2    (txc_d2_w[gi]),
            .td_d1     (td_d1_w[4*gi +: 4]),
            .td_d2     (td_d2_w[4*gi +: 4]),
            .tx_ctl_d1 (tx_ctl_d1_w[gi]),
            .tx_ctl_d2 (tx_ctl_d2_w[gi])
        );
    end

    assign bus.gmii_clk_en = clk_en_w;
    assign bus.speed_act   = speed_act_w;
    assign bus.txc_d1      = txc_d1_w;
    assign bus.txc_d2      = txc_d2_w;
    assign bus.td_d1       = td_d1_w;
    assign bus.td_d2       = td_d2_w;
    assign bus.tx_ctl_d1   = tx_ctl_d1_w;
    assign bus.tx_ctl_d2   = tx_ctl_d2_w;

endmodule
